warp_ahbs_mem: RTL
==================

// Module: warp_ahbs_mem
// PURPOSE
// AHB-Lite subordinate (responder) fronting an internal word-addressed register-array
// memory; the responder-side counterpart to the warp AHB manager interface.
// Accepts single/burst transfers beat by beat, inserts a configurable number of wait
// states, and returns the two-cycle ERROR response for illegal transfers. Serves as
// on-chip scratch RAM and as the bus-functional target for manager-side benches.
// PARAMETERS
// addr_width   64  HADDR width in bits
// data_width   64  HWDATA/HRDATA width; power of two, 32 or 64
// depth        256 memory words of data_width bits; power of two
// wait_states  0   HREADYOUT-low cycles inserted per OKAY data phase (0..15)
// PORTS
// i_ahb_hclk       in   1             clock
// i_ahb_hreset_n   in   1             reset
// i_ahb_hsel       in   1             subordinate select
// i_ahb_haddr      in   addr_width    byte address
// i_ahb_htrans     in   2             IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
// i_ahb_hwrite     in   1             1=write, 0=read
// i_ahb_hsize      in   3             log2 transfer bytes
// i_ahb_hburst     in   3             ignored; every beat is decoded independently
// i_ahb_hprot      in   4             ignored
// i_ahb_hready     in   1             bus HREADY (previous data phase completing)
// i_ahb_hwdata     in   data_width    write data, valid in data phase
// i_ahb_hwstrb     in   data_width/8  byte write strobes, valid in data phase
// o_ahb_hrdata     out  data_width    read data
// o_ahb_hreadyout  out  1             0 extends current data phase
// o_ahb_hresp      out  1             0=OKAY 1=ERROR
// BEHAVIOUR
// - Clock i_ahb_hclk; reset i_ahb_hreset_n is asynchronous, active-low.
// - Reset: hreadyout=1, hresp=0, hrdata=0, state IDLE, wait counter 0. Memory is not reset.
//   Reset mid-transfer aborts the beat with no write commit.
// - Address phase is accepted only when hsel && hready && htrans[1]; haddr, hwrite, hsize
//   are registered then. IDLE/BUSY or unselected -> no data phase (zero-wait OKAY).
// - Decode: OFF=log2(data_width/8); index=haddr[OFF+log2(depth)-1:OFF]. ERROR if haddr >=
//   depth*data_width/8, hsize > OFF, or haddr not aligned to 2**hsize.
// - FSM: IDLE -> DATA (legal beat) or ERR1 (illegal beat).
//   DATA: counter loaded with wait_states; hreadyout=0 while counter!=0, decrement each
//   cycle; when 0 -> hreadyout=1, hresp=0, phase ends; next state from current address phase.
//   ERR1: hreadyout=0, hresp=1 -> ERR2. ERR2: hreadyout=1, hresp=1 -> IDLE/DATA/ERR1.
//   Address phase in ERR2 is accepted like any other; manager may also cancel with IDLE.
// - wait_states=0: one-cycle data phase, back-to-back beats at full rate.
// - Write commit: on the clock edge that ends a DATA write phase (hreadyout=1), byte lane b
//   is written iff hwstrb[b] && lane b within the 2**hsize window at haddr. Errored beats
//   never write.
// - Read: hrdata=mem[index] combinationally in a DATA read phase; 0 in all other cycles.
//   A read immediately following a write to the same word returns the new data.
// - Address-phase signals sampled only when hready=1; they are ignored while a wait or
//   error phase holds hreadyout=0.
// TESTING
// - Reset: assert reset mid-wait -> hreadyout=1, hresp=0, hrdata=0 asynchronously; word unchanged.
// - wait_states=0: NONSEQ write 0x10=0x1122334455667788 strb=FF, then read 0x10 back-to-back
//   -> read data phase hrdata=0x1122334455667788, hreadyout=1 each cycle.
// - Byte write: hsize=0 addr 0x13 data 0xAB<<24 strb=FF onto 0 word -> word reads 0x00000000AB000000.
// - wait_states=3: single read -> hreadyout low exactly 3 cycles, then 1 with valid data.
// - Error: read addr depth*8 (0x800) -> cycle1 ready=0 resp=1, cycle2 ready=1 resp=1;
//   misaligned hsize=2 addr 0x2 write -> same response, memory unchanged.
// - INCR4 SEQ burst 0x20..0x38 with BUSY beat inserted -> 4 writes committed, BUSY gets zero-wait OKAY.

Source files
------------

// File: rtl/warp_ahbs_mem.sv
// rtl/warp_ahbs_mem.sv - AHB-Lite subordinate fronting a word-addressed register-array memory
// Each beat is decoded on its own; illegal beats receive the two-cycle ERROR response.
module warp_ahbs_mem #(
   parameter int addr_width  = 64,
   parameter int data_width  = 64,
   parameter int depth       = 256,
   parameter int wait_states = 0
) (
   input  logic                    i_ahb_hclk,
   input  logic                    i_ahb_hreset_n,
   input  logic                    i_ahb_hsel,
   input  logic [addr_width-1:0]   i_ahb_haddr,
   input  logic [1:0]              i_ahb_htrans,
   input  logic                    i_ahb_hwrite,
   input  logic [2:0]              i_ahb_hsize,
   input  logic [2:0]              i_ahb_hburst,
   input  logic [3:0]              i_ahb_hprot,
   input  logic                    i_ahb_hready,
   input  logic [data_width-1:0]   i_ahb_hwdata,
   input  logic [data_width/8-1:0] i_ahb_hwstrb,
   output logic [data_width-1:0]   o_ahb_hrdata,
   output logic                    o_ahb_hreadyout,
   output logic                    o_ahb_hresp
);
   localparam int OFF   = $clog2(data_width / 8);
   localparam int IDX_W = $clog2(depth);
   localparam int NB    = data_width / 8;
   localparam int LOW_W = OFF + IDX_W;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [LOW_W-1:0]  addr_q, addr_d;
   logic              write_q, write_d;
   logic [2:0]        size_q, size_d;
   logic [data_width-1:0] mem_q [depth];

   logic              accept;
   logic              illegal;
   logic              commit;
   logic [OFF-1:0]    in_mask;
   logic [OFF-1:0]    q_mask;
   logic [NB-1:0]     lane_en;
   logic [IDX_W-1:0]  idx;
   logic              unused_ok;

   assign unused_ok = ^{i_ahb_hburst, i_ahb_hprot, i_ahb_htrans[0]};
   assign accept    = i_ahb_hsel && i_ahb_hready && i_ahb_htrans[1];
   assign idx       = addr_q[LOW_W-1:OFF];

   // Out of range is any set bit above the memory window (depth is a power of two).
   always_comb begin
      in_mask = ~({OFF{1'b1}} << i_ahb_hsize);
      illegal = (|i_ahb_haddr[addr_width-1:LOW_W]) || (i_ahb_hsize > 3'(OFF)) ||
                (|(i_ahb_haddr[OFF-1:0] & in_mask));
   end

   always_comb begin
      q_mask = ~({OFF{1'b1}} << size_q);
      for (int b = 0; b < NB; b++) begin
         lane_en[b] = ((OFF'(b) ^ addr_q[OFF-1:0]) & ~q_mask) == '0;
      end
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      addr_d          = addr_q;
      write_d         = write_q;
      size_d          = size_q;
      o_ahb_hreadyout = 1'b1;
      o_ahb_hresp     = 1'b0;
      commit          = 1'b0;
      case (state_q)
         S_DATA: begin
            if (cnt_q != 4'd0) begin
               o_ahb_hreadyout = 1'b0;
               cnt_d           = cnt_q - 4'd1;
            end else begin
               commit = write_q;
            end
         end
         S_ERR1: begin
            o_ahb_hreadyout = 1'b0;
            o_ahb_hresp     = 1'b1;
            state_d         = S_ERR2;
         end
         S_ERR2:  o_ahb_hresp = 1'b1;
         default: ;
      endcase
      // A new address phase is only taken when the current data phase is completing.
      if (o_ahb_hreadyout) begin
         if (accept) begin
            addr_d  = i_ahb_haddr[LOW_W-1:0];
            write_d = i_ahb_hwrite;
            size_d  = i_ahb_hsize;
            cnt_d   = 4'(wait_states);
            state_d = illegal ? S_ERR1 : S_DATA;
         end else begin
            state_d = S_IDLE;
         end
      end
   end

   always_ff @(posedge i_ahb_hclk or negedge i_ahb_hreset_n) begin
      if (!i_ahb_hreset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         size_q  <= size_d;
      end
   end

   always_ff @(posedge i_ahb_hclk) begin
      if (commit) begin
         for (int b = 0; b < NB; b++) begin
            if (i_ahb_hwstrb[b] && lane_en[b]) begin
               mem_q[idx][8*b +: 8] <= i_ahb_hwdata[8*b +: 8];
            end
         end
      end
   end

   assign o_ahb_hrdata = (state_q == S_DATA && !write_q) ? mem_q[idx] : '0;

endmodule
